// File: rtl/instr_fetch.sv
// Instruction fetch stage: two-state fetch/hold FSM with next-PC selection.
// Optional macro FETCH_ALIGN_TRAP_EN redirects misaligned next-PC to TRAP_VEC.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  pc_src,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] jr_addr,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        align_err
);

  typedef enum logic {S_FETCH = 1'b0, S_HOLD = 1'b1} stateT;

  stateT       stateReg;
  stateT       stateNext;
  logic [31:0] pcReg;
  logic [31:0] instReg;
  logic        alignErrReg;
  logic [31:0] pcPlus4;
  logic [31:0] branchOff;
  logic [31:0] nextPc;
  logic [31:0] pcLoad;
  logic        misaligned;
  logic        captureEn;
  logic        loadEn;

  assign pcPlus4   = pcReg + 32'd4;
  assign branchOff = {{14{instReg[15]}}, instReg[15:0], 2'b00};

  always_comb begin
    nextPc = pcPlus4;
    case (pc_src)
      2'b01:   nextPc = {pcPlus4[31:28], instReg[25:0], 2'b00};
      2'b10:   nextPc = jr_addr;
      2'b00:   nextPc = (branch && zero) ? (pcPlus4 + branchOff) : pcPlus4;
      default: nextPc = pcPlus4;
    endcase
  end

`ifdef FETCH_ALIGN_TRAP_EN
  assign misaligned = |nextPc[1:0];
  assign pcLoad     = misaligned ? TRAP_VEC : nextPc;
`else
  // Low address bits are simply dropped; the trap vector is never used here.
  logic unusedCfg;
  assign misaligned = 1'b0;
  assign pcLoad     = {nextPc[31:2], 2'b00};
  assign unusedCfg  = ^{TRAP_VEC, nextPc[1:0]};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= S_FETCH;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      S_FETCH: if (imem_ready) stateNext = S_HOLD;
      S_HOLD:  if (advance)    stateNext = S_FETCH;
      default: stateNext = S_FETCH;
    endcase
  end

  // Output logic; the request drops combinationally while reset is high.
  always_comb begin
    imem_req   = (stateReg == S_FETCH) && !reset;
    inst_valid = (stateReg == S_HOLD);
    captureEn  = (stateReg == S_FETCH) && imem_ready;
    loadEn     = (stateReg == S_HOLD) && advance;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcReg       <= RESET_PC;
      instReg     <= 32'h0000_0000;
      alignErrReg <= 1'b0;
    end else begin
      if (captureEn) begin
        instReg <= imem_rdata;
      end
      if (loadEn) begin
        pcReg <= pcLoad;
      end
      alignErrReg <= loadEn && misaligned;
    end
  end

  assign imem_addr = pcReg;
  assign pc        = pcReg;
  assign pc_plus4  = pcPlus4;
  assign inst      = instReg;
  assign align_err = alignErrReg;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes expected fetch addresses
// and held instructions; a negedge monitor pops and compares them.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic [1:0]  pc_src;
  logic        branch;
  logic        zero;
  logic [31:0] jr_addr;
  logic        advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        align_err;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pcp4;
  } holdT;

  logic [31:0] fetchQ[$];
  holdT        holdQ[$];
  int          checks = 0;
  int          errors = 0;

  instr_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .pc_src     (pc_src),
    .branch     (branch),
    .zero       (zero),
    .jr_addr    (jr_addr),
    .advance    (advance),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .align_err  (align_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: new request -> pop expected address; stall cycles -> same address;
  // entry to hold -> pop expected instruction/pc.
  initial begin
    logic        inFetch;
    logic        validPrev;
    logic [31:0] curAddr;
    holdT        h;
    inFetch   = 1'b0;
    validPrev = 1'b0;
    curAddr   = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        inFetch   = 1'b0;
        validPrev = 1'b0;
      end else begin
        if (!inFetch && imem_req) begin
          if (fetchQ.size() == 0) begin
            check("unexpected_req", imem_addr, 32'hxxxx_xxxx);
          end else begin
            curAddr = fetchQ.pop_front();
            check("req_addr", imem_addr, curAddr);
          end
          inFetch = 1'b1;
        end else if (inFetch && !inst_valid) begin
          check("stall_req", {31'b0, imem_req}, 32'd1);
          check("stall_addr", imem_addr, curAddr);
        end
        if (inst_valid && !validPrev) begin
          if (holdQ.size() == 0) begin
            check("unexpected_hold", inst, 32'hxxxx_xxxx);
          end else begin
            h = holdQ.pop_front();
            $display("hold pc=%h inst=%h", pc, inst);
            check("hold_inst", inst, h.inst);
            check("hold_pc", pc, h.pc);
            check("hold_pcp4", pc_plus4, h.pcp4);
          end
          inFetch = 1'b0;
        end
        validPrev = inst_valid;
      end
    end
  end

  // Present one instruction word after 'waits' not-ready cycles, pulsing advance meanwhile.
  task automatic fetch(input logic [31:0] data, input int waits,
                       input logic [31:0] atPc);
    holdT h;
    h.inst = data;
    h.pc   = atPc;
    h.pcp4 = atPc + 32'd4;
    holdQ.push_back(h);
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      imem_rdata = 32'hBAD0_0000 + i;
      advance    = (i % 2 == 1);
      @(posedge clk); #1;
    end
    advance    = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = data;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic doAdvance(input logic [1:0] src, input logic br, input logic z,
                           input logic [31:0] jr, input logic [31:0] expPc);
    advance = 1'b0;
    @(posedge clk); #1;
    pc_src  = src;
    branch  = br;
    zero    = z;
    jr_addr = jr;
    advance = 1'b1;
    fetchQ.push_back(expPc);
    @(posedge clk); #1;
    advance = 1'b0;
    pc_src  = 2'b01;
    branch  = 1'b1;
    zero    = 1'b1;
    jr_addr = 32'hFFFF_FFFF;
    check("adv_pc", pc, expPc);
    check("adv_valid", {31'b0, inst_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] trapPc;
    reset      = 1'b1;
    pc_src     = 2'b00;
    branch     = 1'b0;
    zero       = 1'b0;
    jr_addr    = 32'h0;
    advance    = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("rst_inst", inst, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_align", {31'b0, align_err}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    fetchQ.push_back(32'h0000_0000);
    fetch(32'h2008_0005, 0, 32'h0000_0000);
    doAdvance(2'b10, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0040);
    fetch(32'h1000_0003, 0, 32'h0000_0040);
    doAdvance(2'b00, 1'b1, 1'b1, 32'h0, 32'h0000_0050);
    check("br_taken_addr", imem_addr, 32'h0000_0050);
    fetch(32'h1000_0003, 0, 32'h0000_0050);
    doAdvance(2'b00, 1'b1, 1'b0, 32'h0, 32'h0000_0054);
    fetch(32'h1000_FFFE, 0, 32'h0000_0054);
    doAdvance(2'b00, 1'b1, 1'b1, 32'h0, 32'h0000_0050);
    fetch(32'hABCD_0000, 0, 32'h0000_0050);
    doAdvance(2'b10, 1'b0, 1'b0, 32'h1000_0000, 32'h1000_0000);
    fetch(32'h0810_0004, 3, 32'h1000_0000);
    doAdvance(2'b01, 1'b1, 1'b1, 32'h0, 32'h1040_0010);
    fetch(32'h0000_0000, 1, 32'h1040_0010);
    doAdvance(2'b11, 1'b1, 1'b1, 32'h0, 32'h1040_0014);
    fetch(32'h1234_5678, 0, 32'h1040_0014);
    doAdvance(2'b10, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    fetch(32'h1111_1111, 0, 32'hFFFF_FFFC);
    doAdvance(2'b00, 1'b0, 1'b0, 32'h0, 32'h0000_0000);
    fetch(32'h2222_2222, 0, 32'h0000_0000);
`ifdef FETCH_ALIGN_TRAP_EN
    trapPc = 32'h8000_0180;
    doAdvance(2'b10, 1'b0, 1'b0, 32'h0000_0102, trapPc);
    check("align_pulse", {31'b0, align_err}, 32'd1);
`else
    trapPc = 32'h0000_0100;
    doAdvance(2'b10, 1'b0, 1'b0, 32'h0000_0102, trapPc);
    check("align_pulse", {31'b0, align_err}, 32'd0);
`endif
    @(posedge clk); #1;
    check("align_clear", {31'b0, align_err}, 32'd0);
    // Reset lands while a fetch is outstanding and memory answers the same cycle.
    reset      = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'h5555_5555;
    #1;
    check("rst_req_drop", {31'b0, imem_req}, 32'd0);
    @(posedge clk); #1;
    check("rst2_inst", inst, 32'h0);
    check("rst2_pc", pc, 32'h0);
    check("rst2_valid", {31'b0, inst_valid}, 32'd0);
    reset      = 1'b0;
    imem_ready = 1'b0;
    fetchQ.push_back(32'h0000_0000);
    fetch(32'h3333_3333, 1, 32'h0000_0000);
    doAdvance(2'b00, 1'b0, 1'b1, 32'h0, 32'h0000_0004);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("fetchq_empty", fetchQ.size(), 32'd0);
    check("holdq_empty", holdQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
